load_align_unit: RTL and testbench

- Pipelined load-data formatter for the MEM/WB boundary.
- Accepts load requests (opcode, address low bits, old rt value, destination tag) and pairs each with the memory read word returned MEM_LATENCY cycles later.
- Extracts, sign-/zero-extends or merges (lwl/lwr) the addressed lanes, and queues results in a credit-protected FIFO with valid/ready output.
- Adds over the previous load formatter: signed loads, partial-word merge, misalignment detection, parametrised width/latency, backpressure, flush.

---
 rtl/load_align_unit_pkg.sv | 17 +
 rtl/load_align_fifo.sv | 47 ++++
 rtl/load_align_unit.sv | 100 ++++++++++
 tb/tb_load_align_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/load_align_unit_pkg.sv
// load_align_unit_pkg: load opcodes, sideband control struct and lane-index width helper
package load_align_unit_pkg;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  typedef struct packed {
    logic       valid;
    logic [5:0] opcode;
  } sb_ctrl_t;
  function automatic int lane_bits(input int dw);
    return $clog2(dw / 8);
  endfunction
endpackage

// File: rtl/load_align_fifo.sv
// load_align_fifo: show-ahead synchronous FIFO with flush and occupancy count
//   clk, rst    : clock, synchronous active-high reset
//   flush_i     : empty the queue
//   push_i/wdata_i : write an entry
//   pop_i       : drop the head entry
//   rdata_o     : head entry (registered storage), count_o : occupancy
module load_align_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk)
    if (rst) begin
      mem_q <= '{default: '0};
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) mem_q[wr_q] <= wdata_i;
      if (push_i) wr_q <= inc(wr_q);
      if (pop_i) rd_q <= inc(rd_q);
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/load_align_unit.sv
// load_align_unit: pairs load requests with delayed memory words, formats them and queues results
//   req_*  : load request (opcode, byte offset, old rt, tag), accepted on req_valid && req_ready
//   mem_rdata : memory word, valid MEM_LATENCY cycles after accept
//   out_*  : formatted result queue head (data, tag, address error), valid/ready
//   flush  : drops queued and in-flight results
module load_align_unit
  import load_align_unit_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1,
  parameter int FIFO_DEPTH  = 3,
  parameter int TAG_WIDTH   = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [5:0]                         req_opcode,
  input  logic [lane_bits(DATA_WIDTH)-1:0]   req_addr_lo,
  input  logic [DATA_WIDTH-1:0]              req_rt,
  input  logic [TAG_WIDTH-1:0]               req_tag,
  input  logic [DATA_WIDTH-1:0]              mem_rdata,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [TAG_WIDTH-1:0]               out_tag,
  output logic                               out_err
);
  localparam int AW = lane_bits(DATA_WIDTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = 1 + TAG_WIDTH + DATA_WIDTH;
  localparam logic [DATA_WIDTH:0] ERR = {1'b1, {DATA_WIDTH{1'b0}}};
  typedef struct packed {
    sb_ctrl_t                ctrl;
    logic [AW-1:0]           addr;
    logic [DATA_WIDTH-1:0]   rt;
    logic [TAG_WIDTH-1:0]    tag;
  } sb_t;
  sb_t sb_q [MEM_LATENCY];
  sb_t sb_d, tail;
  logic [CW-1:0] cnt_q, cnt_d, fifo_cnt;
  logic accept, pop, push;
  logic [DATA_WIDTH:0] fmt;
  logic [FW-1:0] head;
  // Returns {err, data}; lwl/lwr shift the memory word into place and keep the uncovered rt lanes.
  function automatic logic [DATA_WIDTH:0] fmt_load(input logic [5:0] op, input logic [AW-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] rt,
                                                   input logic [DATA_WIDTH-1:0] rd);
    int sh;
    logic [7:0] b;
    logic [15:0] h;
    logic [DATA_WIDTH-1:0] ones;
    sh = 8 * int'(a);
    b = 8'(rd >> sh);
    h = 16'(rd >> sh);
    ones = '1;
    case (op)
      OP_LB:   return {1'b0, {(DATA_WIDTH-8){b[7]}}, b};
      OP_LBU:  return {{(DATA_WIDTH-7){1'b0}}, b};
      OP_LH:   return a[0] ? ERR : {1'b0, {(DATA_WIDTH-16){h[15]}}, h};
      OP_LHU:  return a[0] ? ERR : {{(DATA_WIDTH-15){1'b0}}, h};
      OP_LW:   return a != '0 ? ERR : {1'b0, rd};
      OP_LWL:  return {1'b0, (rd << (DATA_WIDTH - 8 - sh)) | (rt & (ones >> (sh + 8)))};
      OP_LWR:  return {1'b0, (rd >> sh) | (rt & ~(ones >> sh))};
      default: return ERR;
    endcase
  endfunction
  // Credit check uses only registered count, so out_ready never reaches req_ready.
  assign req_ready = !rst && !flush && cnt_q < CW'(FIFO_DEPTH);
  assign accept = req_valid && req_ready;
  assign pop = out_valid && out_ready;
  assign tail = sb_q[MEM_LATENCY-1];
  assign push = tail.ctrl.valid && !flush;
  assign sb_d = {accept, req_opcode, req_addr_lo, req_rt, req_tag};
  assign cnt_d = cnt_q + CW'(accept) - CW'(pop);
  assign fmt = fmt_load(tail.ctrl.opcode, tail.addr, tail.rt, mem_rdata);
  always_ff @(posedge clk)
    cnt_q <= (rst || flush) ? '0 : cnt_d;
  always_ff @(posedge clk)
    if (rst || flush) sb_q <= '{default: '0};
    else begin
      sb_q[0] <= sb_d;
      for (int i = 1; i < MEM_LATENCY; i++) sb_q[i] <= sb_q[i-1];
    end
  load_align_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i ({fmt[DATA_WIDTH], tail.tag, fmt[DATA_WIDTH-1:0]}),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (fifo_cnt)
  );
  assign out_valid = fifo_cnt != '0;
  assign out_err = head[FW-1];
  assign out_tag = head[DATA_WIDTH +: TAG_WIDTH];
  assign out_data = head[DATA_WIDTH-1:0];
endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: directed and random stimulus against a lane-level reference model
module tb_load_align_unit;
  import load_align_unit_pkg::*;
  localparam int DW = 32, ML = 2, FD = 4, TW = 5, N = DW / 8;
  logic clk = 0, rst = 1, flush = 0, req_valid = 0, out_ready = 0;
  logic [5:0] req_opcode = '0;
  logic [1:0] req_addr_lo = '0;
  logic [DW-1:0] req_rt = '0, mem_rdata = '0;
  logic [TW-1:0] req_tag = '0;
  logic req_ready, out_valid, out_err;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_tag;
  always #5 clk = ~clk;
  load_align_unit #(.DATA_WIDTH(DW), .MEM_LATENCY(ML), .FIFO_DEPTH(FD), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_addr_lo(req_addr_lo), .req_rt(req_rt), .req_tag(req_tag),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err)
  );
  typedef struct {
    logic [5:0] op; int a; logic [DW-1:0] rt; logic [DW-1:0] mem; logic [TW-1:0] tag;
    int due; bit lit_en; logic [DW:0] lit;
  } req_t;
  typedef struct {
    logic [DW:0] res; logic [TW-1:0] tag; int rdy; bit lit_en; logic [DW:0] lit;
  } res_t;
  req_t pend[$];
  res_t expq[$];
  int cyc = 0, n_chk = 0, n_fail = 0, n_vec = 0;
  bit prev_rst = 0, lit_en = 0;
  logic [DW-1:0] mem_next = '0, req_mem = '0;
  logic [DW:0] lit = '0;
  // Reference: build the result lane by lane from the opcode rules; returns {err, data}.
  function automatic logic [DW:0] ref_fmt(input logic [5:0] op, input int a,
                                          input logic [DW-1:0] rt, input logic [DW-1:0] m);
    logic [7:0] ml [N];
    logic [7:0] rl [N];
    logic [7:0] o [N];
    logic [DW-1:0] r;
    bit err, sx;
    int w;
    err = 0; w = 0;
    for (int k = 0; k < N; k++) begin ml[k] = m[8*k +: 8]; rl[k] = rt[8*k +: 8]; o[k] = 8'h00; end
    case (op)
      OP_LB, OP_LBU: w = 1;
      OP_LH, OP_LHU: begin w = 2; err = (a % 2) != 0; end
      OP_LW: begin w = N; err = a != 0; end
      OP_LWL: for (int k = 0; k < N; k++) o[k] = (k >= N - 1 - a) ? ml[k - (N - 1 - a)] : rl[k];
      OP_LWR: for (int k = 0; k < N; k++) o[k] = (k < N - a) ? ml[k + a] : rl[k];
      default: err = 1;
    endcase
    sx = op == OP_LB || op == OP_LH;
    if (w > 0 && !err)
      for (int k = 0; k < N; k++) o[k] = k < w ? ml[a + k] : (sx && ml[a + w - 1][7]) ? 8'hFF : 8'h00;
    for (int k = 0; k < N; k++) r[8*k +: 8] = o[k];
    return err ? {1'b1, {DW{1'b0}}} : {1'b0, r};
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask
  // Compare process: checks outputs every cycle, then advances the model past the coming edge.
  always @(negedge clk) begin
    bit ev;
    req_t p;
    cyc++;
    if (rst) begin
      if (prev_rst) begin
        chk("rst_valid", 64'(out_valid), 0);
        chk("rst_data", 64'(out_data), 0);
        chk("rst_tag", 64'(out_tag), 0);
        chk("rst_err", 64'(out_err), 0);
      end
      pend.delete();
      expq.delete();
    end else begin
      ev = expq.size() > 0 && expq[0].rdy <= cyc;
      chk("out_valid", 64'(out_valid), 64'(ev));
      if (out_valid && ev) begin
        chk("out_data", 64'(out_data), 64'(expq[0].res[DW-1:0]));
        chk("out_err", 64'(out_err), 64'(expq[0].res[DW]));
        chk("out_tag", 64'(out_tag), 64'(expq[0].tag));
        if (expq[0].lit_en) chk("literal", 64'({out_err, out_data}), 64'(expq[0].lit));
      end
      chk("req_ready", 64'(req_ready), 64'(!flush && (pend.size() + expq.size()) < FD));
      chk("credit_count", 64'(dut.cnt_q), 64'(pend.size() + expq.size()));
      chk("occupancy_le_depth", 64'(int'(dut.u_fifo.count_o) <= FD), 1);
      if (flush) begin
        pend.delete();
        expq.delete();
      end else begin
        if (out_valid && ev && out_ready) void'(expq.pop_front());
        if (pend.size() > 0 && pend[0].due == cyc) begin
          p = pend.pop_front();
          expq.push_back('{ref_fmt(p.op, p.a, p.rt, p.mem), p.tag, cyc + 1, p.lit_en, p.lit});
        end
        if (req_valid && req_ready) begin
          pend.push_back('{req_opcode, int'(req_addr_lo), req_rt, req_mem, req_tag, cyc + ML, lit_en, lit});
          n_vec++;
        end
      end
    end
    prev_rst = rst;
    mem_next = (pend.size() > 0 && pend[0].due == cyc + 1) ? pend[0].mem : $urandom;
  end
  initial forever begin
    @(posedge clk);
    #1;
    mem_rdata = mem_next;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [5:0] op, input int a, input logic [DW-1:0] rt, input logic [DW-1:0] m,
                      input logic [TW-1:0] tag, input bit le, input logic [DW:0] lv);
    int i;
    req_valid = 1; req_opcode = op; req_addr_lo = 2'(a); req_rt = rt; req_mem = m; req_tag = tag;
    lit_en = le; lit = lv;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) break;
    end
    if (i == 200) begin
      n_fail++;
      $display("FAIL send_timeout: tag %0d never accepted", tag);
    end
    step();
    req_valid = 0;
    lit_en = 0;
  endtask
  logic [5:0] ops [8] = '{OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR, 6'h2B};
  initial begin
    int base, idx;
    chk("pin_lb", 64'(ref_fmt(OP_LB, 3, 0, 32'h8081_7F02)), 64'({1'b0, 32'hFFFF_FF80}));
    chk("pin_lh", 64'(ref_fmt(OP_LH, 2, 0, 32'h8081_7F02)), 64'({1'b0, 32'hFFFF_8081}));
    chk("pin_lwl", 64'(ref_fmt(OP_LWL, 1, 32'hAABB_CCDD, 32'h4433_2211)), 64'({1'b0, 32'h2211_CCDD}));
    chk("pin_lwr", 64'(ref_fmt(OP_LWR, 1, 32'hAABB_CCDD, 32'h4433_2211)), 64'({1'b0, 32'hAA44_3322}));
    chk("pin_lh_err", 64'(ref_fmt(OP_LH, 1, 0, 32'h8081_7F02)), 64'({1'b1, 32'h0}));
    rst = 1; req_valid = 1; req_opcode = OP_LB;
    repeat (3) step();
    rst = 0; req_valid = 0;
    step();
    chk("ready_after_rst", 64'(req_ready), 1);
    out_ready = 1;
    send(OP_LB,  3, 0, 32'h8081_7F02, 1, 1, {1'b0, 32'hFFFF_FF80});
    send(OP_LBU, 3, 0, 32'h8081_7F02, 2, 1, {1'b0, 32'h0000_0080});
    send(OP_LH,  2, 0, 32'h8081_7F02, 3, 1, {1'b0, 32'hFFFF_8081});
    send(OP_LHU, 0, 0, 32'h8081_7F02, 4, 1, {1'b0, 32'h0000_7F02});
    send(OP_LW,  0, 0, 32'h8081_7F02, 5, 1, {1'b0, 32'h8081_7F02});
    send(OP_LWL, 1, 32'hAABB_CCDD, 32'h4433_2211, 6, 1, {1'b0, 32'h2211_CCDD});
    send(OP_LWR, 1, 32'hAABB_CCDD, 32'h4433_2211, 7, 1, {1'b0, 32'hAA44_3322});
    send(OP_LWL, 3, 32'hAABB_CCDD, 32'h4433_2211, 8, 1, {1'b0, 32'h4433_2211});
    send(OP_LH,  1, 0, 32'h8081_7F02, 9, 1, {1'b1, 32'h0});
    send(OP_LW,  2, 0, 32'h8081_7F02, 10, 1, {1'b1, 32'h0});
    send(6'h2B,  0, 0, 32'h8081_7F02, 11, 1, {1'b1, 32'h0});
    send(OP_LB,  0, 0, 32'h8081_7F02, 12, 1, {1'b0, 32'h0000_0002});
    repeat (8) step();
    out_ready = 0;
    base = n_vec;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1; req_opcode = OP_LW; req_addr_lo = 0; req_rt = $urandom; req_mem = $urandom;
      req_tag = 5'(16 + i);
      step();
    end
    req_valid = 0;
    repeat (3) step();
    chk("bp_accepted", 64'(n_vec - base), 4);
    chk("bp_ready_low", 64'(req_ready), 0);
    out_ready = 1;
    repeat (8) step();
    send(OP_LW, 0, 0, $urandom, 20, 0, '0);
    send(OP_LW, 0, 0, $urandom, 21, 0, '0);
    repeat (8) step();
    chk("bp_total", 64'(n_vec - base), 6);
    out_ready = 0;
    send(OP_LBU, 1, 0, 32'h0000_5500, 24, 1, {1'b0, 32'h55});
    repeat (ML + 2) step();
    send(OP_LW, 0, 0, $urandom, 25, 0, '0);
    send(OP_LW, 0, 0, $urandom, 26, 0, '0);
    flush = 1; req_valid = 1; req_opcode = OP_LB; req_tag = 27;
    step();
    flush = 0; req_valid = 0;
    chk("flush_valid", 64'(out_valid), 0);
    chk("flush_count", 64'(dut.cnt_q), 0);
    out_ready = 1;
    send(OP_LBU, 2, 0, 32'h00C3_0000, 28, 1, {1'b0, 32'h0000_00C3});
    repeat (ML + 3) step();
    for (int i = 0; i < 1500; i++) begin
      idx = $urandom_range(0, 8);
      req_valid = $urandom_range(0, 2) != 0;
      req_opcode = idx == 8 ? 6'($urandom) : ops[idx];
      req_addr_lo = 2'($urandom);
      req_rt = $urandom; req_mem = $urandom; req_tag = 5'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 49) == 0;
      rst = i >= 1000 && i < 1002;
      step();
    end
    rst = 0; flush = 0; req_valid = 0; out_ready = 1;
    repeat (ML + FD + 5) step();
    chk("drain_model_empty", 64'(pend.size() + expq.size()), 0);
    chk("drain_valid", 64'(out_valid), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
